mips_datapath_alu_muldiv_seq: RTL and testbench
===============================================

MIPS_DATAPATH_ALU_MULDIV_SEQ -- requirements
Module: mips_datapath_alu_muldiv_seq

Interface
REQ-001 Parameter DATA_W, default 32, operand/HI/LO width; SHALL be even and >= 4.
REQ-002 ctrl  input  bundle  codebase control bundle; carries the single clock (rising edge) and reset (asynchronous, active-high).
REQ-003 start  input  1  request new operation; sampled on each rising edge.
REQ-004 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (no-op).
REQ-005 data1  input  DATA_W  operand A / dividend / MTHI-MTLO source.
REQ-006 data2  input  DATA_W  operand B / divisor.
REQ-007 flush  input  1  abort in-flight operation (pipeline squash).
REQ-008 readHiLo  input  1  decode stage wants HI or LO (MFHI/MFLO).
REQ-009 hi, lo  output  DATA_W each  architectural HI/LO registers.
REQ-010 busy  output  1  iterative op in progress.
REQ-011 done  output  1  one-cycle pulse, result committed.
REQ-012 stall  output  1  pipeline hold request.

Function
REQ-013 States IDLE, RUN, FIX; single always-registered FSM, no other state.
REQ-014 IDLE, start=1, op in {0..3}: latch operands (absolute values for signed ops, record result signs), clear iteration counter, go RUN.
REQ-015 IDLE, start=1, op=4/5: write data1 to hi/lo respectively on that edge; stay IDLE; busy stays 0; no done pulse.
REQ-016 IDLE, start=1, op=6/7: no state change, no register write.
REQ-017 RUN: one bit per cycle -- shift-add for multiply, restoring shift-subtract for divide; counter increments; after DATA_W RUN edges go FIX.
REQ-018 FIX: apply sign correction, write hi/lo, go IDLE; done=1 for exactly the cycle after the FIX edge.
REQ-019 Latency: start edge E0 -> hi/lo updated at edge E0+DATA_W+1; busy=1 from after E0 through that edge.
REQ-020 MULT/MULTU: {hi,lo} = full 2*DATA_W-bit product, signed/unsigned; no overflow.
REQ-021 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of dividend.
REQ-022 Divisor 0 (any sign mode): lo = all ones, hi = data1 unchanged; no trap, normal latency.
REQ-023 DIV of most-negative by -1: lo = most-negative value, hi = 0.
REQ-024 start while busy: ignored; in-flight op unaffected (upstream shall hold via stall).
REQ-025 flush=1 in RUN or FIX: return to IDLE next edge, hi/lo unchanged, no done; flush has priority over FIX write.
REQ-026 flush and start on same IDLE edge: flush wins, start ignored (including MTHI/MTLO).
REQ-027 stall = busy & (readHiLo | start); combinational, zero when IDLE.
REQ-028 hi/lo change only on REQ-015 or REQ-018 edges.

Reset
REQ-029 reset asserted: asynchronously force IDLE, hi=0, lo=0, busy=0, done=0, counter=0, operand latches 0.
REQ-030 reset mid-operation: operation discarded, no done pulse; first start after deassertion accepted normally.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done single pulse, busy 33 cycles.
REQ-032 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive edges -> hi/lo updated next edge each, busy/done never high.
REQ-035 Start MULT, flush at RUN cycle 10 -> IDLE next edge, hi/lo keep prior values, no done; readHiLo during RUN -> stall=1.
REQ-036 Assert reset at RUN cycle 5 -> all outputs 0 immediately (before next clock edge); new DIVU 100/7 after release -> lo=14, hi=2.

Source files
------------

// File: rtl/mips_datapath_alu_muldiv_seq_if.sv
// Signal bundle for the iterative multiply/divide unit.
// Carries the unit's clock and reset together with the issue side
// (start, op, data1, data2, flush, readHiLo) and the result side
// (hi, lo, busy, done, stall).
//   master : pipeline/issue side
//   slave  : the multiply/divide unit
interface mips_datapath_alu_muldiv_seq_if #(
  parameter int unsigned DATA_W = 32
) (
  input logic clk,
  input logic rst
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              flush;
  logic              readHiLo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              stall;

  modport master (
    input  clk, rst, hi, lo, busy, done, stall,
    output start, op, data1, data2, flush, readHiLo
  );

  modport slave (
    input  clk, rst, start, op, data1, data2, flush, readHiLo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mips_datapath_alu_muldiv_seq.sv
// Iterative MIPS HI/LO unit: MULT/MULTU (shift-add) and DIV/DIVU
// (restoring shift-subtract), one bit per cycle, plus MTHI/MTLO.
// Operands are latched as magnitudes; signs are reapplied in FIX.
// Ports (through ctrl):
//   clk, rst          clock (rising edge), async active-high reset
//   start, op         issue request and opcode (0..5, 6/7 no-op)
//   data1, data2      operands
//   flush             squash the in-flight operation
//   readHiLo          decode wants HI/LO (drives stall while busy)
//   hi, lo            architectural HI/LO
//   busy, done, stall status; done pulses one cycle after commit
module mips_datapath_alu_muldiv_seq #(
  parameter int unsigned DATA_W = 32
) (
  mips_datapath_alu_muldiv_seq_if.slave ctrl
);
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;     // multiplicand / divisor magnitude
  logic [DATA_W-1:0]   b_q, b_d;     // multiplier / dividend -> low product / quotient
  logic [DATA_W-1:0]   acc_q, acc_d; // high partial product / remainder
  logic                is_div_q, is_div_d;
  logic                neg_q_q, neg_q_d; // negate product or quotient
  logic                neg_r_q, neg_r_d; // negate remainder
  logic                div0_q, div0_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;

  logic                signed_op, sign1, sign2;
  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod, prod_fix;

  always_comb begin
    signed_op = (ctrl.op == 3'd0) || (ctrl.op == 3'd2);
    sign1     = signed_op & ctrl.data1[DATA_W-1];
    sign2     = signed_op & ctrl.data2[DATA_W-1];
    abs1      = sign1 ? -ctrl.data1 : ctrl.data1;
    abs2      = sign2 ? -ctrl.data2 : ctrl.data2;

    mul_sum   = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : '0)};
    div_shift = {acc_q, b_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, a_q};
    prod      = {acc_q, b_q};
    prod_fix  = neg_q_q ? -prod : prod;

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl.start && !ctrl.flush) begin
          unique case (ctrl.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d = ctrl.op[1];
              a_d      = ctrl.op[1] ? abs2 : abs1;
              b_d      = ctrl.op[1] ? abs1 : abs2;
              acc_d    = '0;
              cnt_d    = '0;
              neg_q_d  = sign1 ^ sign2;
              neg_r_d  = sign1;
              div0_d   = (ctrl.data2 == '0);
              state_d  = RUN;
            end
            3'd4:    hi_d = ctrl.data1;
            3'd5:    lo_d = ctrl.data1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (ctrl.flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (div_shift >= {1'b0, a_q}) begin
              acc_d = div_diff[DATA_W-1:0];
              b_d   = {b_q[DATA_W-2:0], 1'b1};
            end else begin
              acc_d = div_shift[DATA_W-1:0];
              b_d   = {b_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            // Carry of the add shifts into acc; product LSBs shift into b.
            acc_d = mul_sum[DATA_W:1];
            b_d   = {mul_sum[0], b_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!ctrl.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Zero divisor yields all-ones quotient regardless of sign.
            lo_d = div0_q ? '1 : (neg_q_q ? -b_q : b_q);
            hi_d = neg_r_q ? -acc_q : acc_q;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ctrl.clk or posedge ctrl.rst) begin
    if (ctrl.rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign ctrl.hi    = hi_q;
  assign ctrl.lo    = lo_q;
  assign ctrl.busy  = (state_q != IDLE);
  assign ctrl.done  = done_q;
  assign ctrl.stall = (state_q != IDLE) & (ctrl.readHiLo | ctrl.start);
endmodule

// File: tb/tb_mips_datapath_alu_muldiv_seq.sv
module tb_mips_datapath_alu_muldiv_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_datapath_alu_muldiv_seq_if #(.DATA_W(W)) bus (.clk(clk), .rst(rst));
  mips_datapath_alu_muldiv_seq #(.DATA_W(W)) dut (.ctrl(bus));

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  // Reference: HI/LO outcome from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, b,
                       output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = exp_hi;
    l = exp_lo;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd2: if (b == 0) begin l = '1; h = a; end
            else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
      3'd3: if (b == 0) begin l = '1; h = a; end
            else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] d1, d2);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.data1 = d1; bus.data2 = d2;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] d1, d2, input string name);
    logic [W-1:0] eh, el;
    int lat, busy_cnt;
    model(op, d1, d2, eh, el);
    issue(op, d1, d2);
    lat = 0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) lat = k;
    end
    tests++;
    if (lat !== W + 1) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, W + 1);
    end
    tests++;
    if (busy_cnt !== W + 1) begin
      fails++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, W + 1);
    end
    tests++;
    if (bus.hi !== eh || bus.lo !== el) begin
      fails++; $display("FAIL %s hilo: got %h_%h want %h_%h", name, bus.hi, bus.lo, eh, el);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0) begin
      fails++; $display("FAIL %s done_pulse: got %b want 0", name, bus.done);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stall} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h_%h %b%b%b want all 0",
                        bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    tests++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      fails++; $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
    end
    run_op(3'd2, -32'sd7, 32'd2, "div_neg7_2");
    run_op(3'd0, -32'sd3, 32'd5, "mult_neg3_5");
    run_op(3'd3, 32'h1234, 32'd0, "divu_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
    tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
      fails++; $display("FAIL div_min_const: got %h_%h want 00000000_80000000", bus.hi, bus.lo);
    end
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, "div_neg_by_zero");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] d1, d2;
    for (int i = 0; i < 14; i++) begin
      op = 3'($urandom_range(0, 3));
      d1 = $urandom;
      d2 = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 2) == 0) d2 = d2 >> $urandom_range(16, 31);
      run_op(op, d1, d2, "random");
    end
  endtask

  task automatic test_mthi_mtlo();
    int bad_status = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'hDEAD_BEEF; bus.data2 = '0;
    @(posedge clk); #1;
    if (bus.busy || bus.done) bad_status++;
    tests++;
    if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== exp_lo) begin
      fails++; $display("FAIL mthi: got %h_%h want deadbeef_%h", bus.hi, bus.lo, exp_lo);
    end
    bus.op = 3'd5; bus.data1 = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy || bus.done) bad_status++;
    tests++;
    if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL mtlo: got %h_%h want deadbeef_0badf00d", bus.hi, bus.lo);
    end
    exp_hi = 32'hDEAD_BEEF;
    exp_lo = 32'h0BAD_F00D;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) bad_status++;
    end
    tests++;
    if (bad_status !== 0) begin
      fails++; $display("FAIL mtx_status: got %0d busy/done samples want 0", bad_status);
    end
  endtask

  task automatic test_reserved();
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);
    tests++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.busy !== 1'b0) begin
      fails++; $display("FAIL reserved_op: got %h_%h busy=%b want %h_%h busy=0",
                        bus.hi, bus.lo, bus.busy, exp_hi, exp_lo);
    end
  endtask

  task automatic test_flush_run();
    int done_seen = 0;
    issue(3'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    #1;
    bus.readHiLo = 1'b1;
    #1;
    tests++;
    if (bus.stall !== 1'b1) begin
      fails++; $display("FAIL stall_readhilo: got %b want 1", bus.stall);
    end
    bus.readHiLo = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL flush_run_idle: busy got %b want 0", bus.busy);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    tests++;
    if (done_seen !== 0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      fails++; $display("FAIL flush_run_keep: got %h_%h done=%0d want %h_%h done=0",
                        bus.hi, bus.lo, done_seen, exp_hi, exp_lo);
    end
    bus.readHiLo = 1'b1;
    #1;
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++; $display("FAIL stall_idle: got %b want 0", bus.stall);
    end
    bus.readHiLo = 1'b0;
  endtask

  task automatic test_flush_fix();
    int done_seen = 0;
    issue(3'd3, 32'd1000, 32'd3);
    repeat (W) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (bus.done) done_seen++;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    tests++;
    if (done_seen !== 0 || bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      fails++; $display("FAIL flush_fix: got %h_%h done=%0d busy=%b want %h_%h done=0 busy=0",
                        bus.hi, bus.lo, done_seen, bus.busy, exp_hi, exp_lo);
    end
  endtask

  task automatic test_flush_start_idle();
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.op = 3'd1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      fails++; $display("FAIL flush_start_idle: got %h_%h busy=%b want %h_%h busy=0",
                        bus.hi, bus.lo, bus.busy, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eh, el;
    int lat = 0;
    model(3'd2, 32'd12345, -32'sd17, eh, el);
    issue(3'd2, 32'd12345, -32'sd17);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'h5555_AAAA; bus.data2 = 32'd9;
    #1;
    tests++;
    if (bus.stall !== 1'b1) begin
      fails++; $display("FAIL stall_start_busy: got %b want 1", bus.stall);
    end
    @(posedge clk); #1;
    bus.op = 3'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 8; k <= 100 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) lat = k;
    end
    tests++;
    if (lat !== W + 1 || bus.hi !== eh || bus.lo !== el) begin
      fails++; $display("FAIL start_while_busy: got lat=%0d %h_%h want lat=%0d %h_%h",
                        lat, bus.hi, bus.lo, W + 1, eh, el);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic test_reset_mid();
    issue(3'd0, 32'h7FFF_0001, 32'h0000_0003);
    repeat (4) @(posedge clk);
    #2;
    bus.readHiLo = 1'b1;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stall} !== '0) begin
      fails++; $display("FAIL reset_mid_async: got %h_%h %b%b%b want all 0",
                        bus.hi, bus.lo, bus.busy, bus.done, bus.stall);
    end
    bus.readHiLo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(3'd3, 32'd100, 32'd7, "divu_after_reset");
    tests++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      fails++; $display("FAIL divu_100_7_const: got %0d r %0d want 14 r 2", bus.lo, bus.hi);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.data1 = '0; bus.data2 = '0;
    bus.flush = 1'b0; bus.readHiLo = 1'b0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_reserved();
    test_flush_run();
    test_flush_fix();
    test_flush_start_idle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
